// File: rtl/sp_ram_pkg.sv
// Shared definitions for the clearable single-port scratchpad RAM:
// read-during-write mode codes, controller states and lane-count helper.
package sp_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int calc_nlane(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/sp_ram_clr_if.sv
// Access/status bundle between local control logic (master) and the
// clearable RAM (slave).
interface sp_ram_clr_if
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANE_W = 4,
    parameter int ADDR_W = 4
);
    localparam int NLANE = calc_nlane(DATA_W, LANE_W);

    logic              clr_req;
    logic              en;
    logic              we;
    logic [NLANE-1:0]  be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              clr_done;
    logic              err;

    modport master (
        output clr_req, en, we, be, addr, din,
        input  dout, dout_valid, busy, clr_done, err
    );

    modport slave (
        input  clr_req, en, we, be, addr, din,
        output dout, dout_valid, busy, clr_done, err
    );

endinterface

// File: rtl/sp_ram_array.sv
// Storage array: one lane-masked write port and a registered read port that
// can return either the stored word or the word being written this cycle.
module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANE_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                                 clk,
    input  logic                                 wr_en,
    input  logic [calc_nlane(DATA_W, LANE_W)-1:0] be,
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [DATA_W-1:0]                    wdata,
    input  logic                                 rd_en,
    input  logic                                 rd_merge,
    input  logic                                 rd_zero,
    output logic [DATA_W-1:0]                    rdata
);
    localparam int NLANE = calc_nlane(DATA_W, LANE_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] merged_d;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Word as it will look after this cycle's write; lanes without be keep old data.
    always_comb begin
        merged_d = mem_q[addr];
        for (int k = 0; k < NLANE; k++) begin
            if (be[k]) begin
                merged_d[k*LANE_W +: LANE_W] = wdata[k*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_zero) begin
            rdata_d = '0;
        end else if (rd_en) begin
            rdata_d = rd_merge ? merged_d : mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= merged_d;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sp_ram_clr.sv
// Clearable single-port RAM: clear engine FSM, clear/user arbitration and
// read-during-write selection around the storage array.
module sp_ram_clr
    import sp_ram_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter int                 LANE_W   = 4,
    parameter int                 ADDR_W   = 4,
    parameter int                 RDW_MODE = 0,
    parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
    input  logic          clk,
    input  logic          rst,
    sp_ram_clr_if.slave   bus
);
    localparam int NLANE = calc_nlane(DATA_W, LANE_W);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              dout_valid_q, dout_valid_d;
    logic              clr_done_q, clr_done_d;
    logic              err_q, err_d;

    logic              arr_wr;
    logic [NLANE-1:0]  arr_be;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_rd;
    logic              arr_merge;
    logic [DATA_W-1:0] arr_rdata;

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        dout_valid_d = 1'b0;
        clr_done_d   = 1'b0;
        err_d        = 1'b0;
        arr_wr       = 1'b0;
        arr_be       = '0;
        arr_addr     = bus.addr;
        arr_wdata    = bus.din;
        arr_rd       = 1'b0;
        arr_merge    = 1'b0;

        unique case (state_q)
            CLEAR: begin
                // Clear engine owns the port; any user access this cycle is refused.
                arr_wr     = 1'b1;
                arr_be     = '1;
                arr_addr   = clr_addr_q;
                arr_wdata  = CLR_VAL;
                clr_addr_d = clr_addr_q + 1'b1;
                err_d      = bus.en;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (bus.clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                    err_d      = bus.en;
                end else if (bus.en) begin
                    if (bus.we) begin
                        arr_wr       = 1'b1;
                        arr_be       = bus.be;
                        arr_rd       = (RDW_MODE != RDW_NO_CHANGE);
                        arr_merge    = (RDW_MODE == RDW_WRITE_FIRST);
                        dout_valid_d = (RDW_MODE != RDW_NO_CHANGE);
                    end else begin
                        arr_rd       = 1'b1;
                        dout_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset blocks every array access; the read register is zeroed instead.
        if (rst) begin
            arr_wr = 1'b0;
            arr_rd = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            dout_valid_q <= 1'b0;
            clr_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            dout_valid_q <= dout_valid_d;
            clr_done_q   <= clr_done_d;
            err_q        <= err_d;
        end
    end

    sp_ram_array #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .wr_en    (arr_wr),
        .be       (arr_be),
        .addr     (arr_addr),
        .wdata    (arr_wdata),
        .rd_en    (arr_rd),
        .rd_merge (arr_merge),
        .rd_zero  (rst),
        .rdata    (arr_rdata)
    );

    assign bus.dout       = arr_rdata;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q == CLEAR);
    assign bus.clr_done   = clr_done_q;
    assign bus.err        = err_q;

endmodule
